// File: rtl/mux_n_1_stream_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
interface mux_n_1_stream_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [SEL_W-1:0]   out_chan;
  logic               out_ready;

  // Environment side: drives producer streams and consumer ready.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );

endinterface

// File: rtl/mux_n_1_stream.sv
// N:1 stream multiplexer, fixed-select or round-robin, one registered output slot.
module mux_n_1_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  mux_n_1_stream_if.slave  bus
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic [SEL_W-1:0] r_last;

  logic             w_space;
  logic             w_has;
  logic [SEL_W-1:0] w_c;
  logic             w_hi_has;
  logic [SEL_W-1:0] w_hi_c;
  logic             w_lo_has;
  logic [SEL_W-1:0] w_lo_c;
  logic [WIDTH-1:0] w_data;
  logic [N-1:0]     w_ready;

  assign w_space = !r_out_valid || bus.out_ready;

  // Channel choice; round-robin prefers the first valid above last, else wraps to the lowest.
  always_comb begin
    w_has    = 1'b0;
    w_c      = '0;
    w_hi_has = 1'b0;
    w_hi_c   = '0;
    w_lo_has = 1'b0;
    w_lo_c   = '0;
    if (!mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (SEL_W'(i) == sel && bus.in_valid[i]) begin
          w_has = 1'b1;
          w_c   = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.in_valid[i]) begin
          if (SEL_W'(i) > r_last) begin
            if (!w_hi_has) begin
              w_hi_has = 1'b1;
              w_hi_c   = SEL_W'(i);
            end
          end else if (!w_lo_has) begin
            w_lo_has = 1'b1;
            w_lo_c   = SEL_W'(i);
          end
        end
      end
      w_has = w_hi_has || w_lo_has;
      w_c   = w_hi_has ? w_hi_c : w_lo_c;
    end
  end

  // Data slice of the chosen channel and the one-hot ready vector.
  always_comb begin
    w_data  = '0;
    w_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SEL_W'(i) == w_c) begin
        w_data = bus.in_data[i*WIDTH +: WIDTH];
      end
      w_ready[i] = w_space && w_has && (SEL_W'(i) == w_c);
    end
  end

  // Output slot: load on accept (replacing a draining word), clear valid on drain only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_last      <= SEL_W'(N - 1);
    end else if (w_space && w_has) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_chan  <= w_c;
      if (mode) begin
        r_last <= w_c;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;

endmodule
